// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC front end and its temperature consumer.
// Producer and consumer read code width and thresholds from here.
package adc_pkg;

  localparam int ADC_DATA_W = 8;

  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_SAMPLE_PERIOD = 256;
  localparam int DEF_LEAD_BITS = 1;

  localparam logic [ADC_DATA_W-1:0] TEMP_THRESH_LO = 8'd192;
  localparam logic [ADC_DATA_W-1:0] TEMP_THRESH_HI = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_CS_HOLD  = 3'd4
  } adc_state_t;

  function automatic int conv_cycles(
    input int div,
    input int lead,
    input int data
  );
    return 2 * div * (lead + data) + 2 * div;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer, cleared by synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_serial_reader.sv
// Periodic reader for an ADC0831-style serial converter.
// Emits each finished conversion as a held word plus a one-cycle strobe.
module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int DATA_BITS     = ADC_DATA_W,
  parameter int LEAD_BITS     = DEF_LEAD_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 adc_sdo,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] adc_out,
  output logic                 adc_valid,
  output logic                 busy
);

  localparam int TOTAL_BITS = LEAD_BITS + DATA_BITS;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam int BIT_W = $clog2(TOTAL_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_LEAD = BIT_W'(LEAD_BITS);

  adc_state_t state, next_state;

  logic [DIV_W-1:0]     div_cnt;
  logic [PER_W-1:0]     per_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 sdo_s;
  logic                 div_done;
  logic                 start;
  logic                 last_bit;
  logic                 sample;
  logic                 finish;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (adc_sdo),
    .q     (sdo_s)
  );

  assign div_done = (div_cnt == DIV_LAST);
  assign start    = enable && (per_cnt == PER_LAST);
  assign last_bit = (bit_idx == BIT_LAST);
  assign sample   = (state == ST_SHIFT_HI) && div_done;
  assign finish   = (state == ST_CS_HOLD) && div_done;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt <= '0;
    end else if (!enable || per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:     if (start) next_state = ST_CS_SETUP;
      ST_CS_SETUP: if (div_done) next_state = ST_SHIFT_LO;
      ST_SHIFT_LO: if (div_done) next_state = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (div_done) begin
          next_state = last_bit ? ST_CS_HOLD : ST_SHIFT_LO;
        end
      end
      ST_CS_HOLD:  if (div_done) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Pin levels are decoded from next_state so they land in flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b0;
      adc_valid <= 1'b0;
    end else begin
      state     <= next_state;
      adc_cs_n  <= (next_state == ST_IDLE);
      adc_sclk  <= (next_state == ST_SHIFT_HI);
      adc_valid <= finish;
      if (state == ST_IDLE || next_state != state) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx <= '0;
      shreg   <= '0;
      adc_out <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        bit_idx <= '0;
        shreg   <= '0;
      end else if (sample) begin
        if (bit_idx >= BIT_LEAD) begin
          shreg <= {shreg[DATA_BITS-2:0], sdo_s};
        end
        bit_idx <= bit_idx + 1'b1;
      end
      if (finish) begin
        adc_out <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader with a behavioural ADC0831 model.
module tb_adc_serial_reader;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       adc_sdo;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [7:0] adc_out;
  logic       adc_valid;
  logic       busy;

  logic       model_sdo;
  logic       noise;
  logic [8:0] seq;

  int errors;
  int checks;
  int cyc;
  int idx;
  int cs_falls;
  int cs_cyc;
  int sclk_rises;
  int conv_rises;
  int valid_cnt;
  int valid_cyc;
  logic prev_cs;
  logic prev_sclk;

  assign adc_sdo = model_sdo ^ noise;

  adc_serial_reader dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .adc_sdo   (adc_sdo),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .adc_out   (adc_out),
    .adc_valid (adc_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: lead bit on cs_n fall, next bit after each sclk fall.
  initial begin
    idx = 9; cs_falls = 0; cs_cyc = 0; sclk_rises = 0;
    conv_rises = 0; valid_cnt = 0; valid_cyc = 0;
    prev_cs = 1'b1; prev_sclk = 1'b0; model_sdo = 1'b0;
  end

  always @(negedge clk) begin
    if (prev_cs && !adc_cs_n) begin
      idx = 0;
      cs_falls++;
      cs_cyc = cyc;
      conv_rises = 0;
    end else if (prev_sclk && !adc_sclk && idx < 9) begin
      idx++;
    end
    if (!prev_sclk && adc_sclk) begin
      sclk_rises++;
      conv_rises++;
    end
    if (adc_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    model_sdo = (!adc_cs_n && idx < 9) ? seq[8-idx] : 1'b0;
    prev_cs = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_cs_fall(input string tag);
    int n0;
    int k;
    n0 = cs_falls;
    k = 0;
    while (cs_falls == n0 && k < 600) begin
      step();
      k++;
    end
    if (cs_falls == n0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_valid(input string tag);
    int n0;
    int k;
    n0 = valid_cnt;
    k = 0;
    while (valid_cnt == n0 && k < 600) begin
      step();
      k++;
    end
    if (valid_cnt == n0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_rises(input int n, input string tag);
    int k;
    k = 0;
    while (conv_rises < n && k < 200) begin
      step();
      k++;
    end
    if (conv_rises < n) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cs_n"}, int'(adc_cs_n), 1);
    chk({tag, "_sclk"}, int'(adc_sclk), 0);
    chk({tag, "_out"}, int'(adc_out), 0);
    chk({tag, "_valid"}, int'(adc_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  int en_cyc;
  int prev_valid_cyc;
  int n_cs;
  int n_sclk;
  int n_valid;
  logic [3:0] pat;

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    enable = 1'b0;
    noise = 1'b0;
    seq = 9'h000;
    pat = 4'b1011;

    for (int i = 0; i < 3; i++) begin
      noise = pat[i];
      step();
      chk_idle("reset");
    end
    reset = 1'b0;
    noise = 1'b0;
    step();
    chk_idle("post_reset");

    seq = {1'b0, 8'hC0};
    en_cyc = cyc;
    enable = 1'b1;
    n_sclk = sclk_rises;
    wait_cs_fall("c0_cs");
    chk("c0_start_cycle", cs_cyc - en_cyc, 256);
    step();
    chk("c0_busy", int'(busy), 1);
    wait_valid("c0_valid");
    chk("c0_latency", valid_cyc - cs_cyc, 80);
    chk("c0_data", int'(adc_out), 8'hC0);
    chk("c0_sclk_rises", sclk_rises - n_sclk, 9);
    seq = {1'b0, 8'hFF};
    step();
    chk("c0_pulse_width", int'(adc_valid), 0);
    chk("c0_cs_release", int'(adc_cs_n), 1);

    prev_valid_cyc = valid_cyc;
    wait_cs_fall("ff_cs");
    chk("c0_hold", int'(adc_out), 8'hC0);
    wait_valid("ff_valid");
    chk("ff_data", int'(adc_out), 8'hFF);
    chk("ff_spacing", valid_cyc - prev_valid_cyc, 256);
    seq = {1'b0, 8'h00};

    prev_valid_cyc = valid_cyc;
    n_valid = valid_cnt;
    wait_valid("zero_valid");
    chk("zero_data", int'(adc_out), 8'h00);
    chk("zero_spacing", valid_cyc - prev_valid_cyc, 256);
    chk("zero_one_pulse", valid_cnt - n_valid, 1);
    seq = {1'b1, 8'h5A};

    wait_valid("lead_valid");
    chk("lead_discard", int'(adc_out), 8'h5A);
    seq = {1'b1, 8'h3C};

    wait_cs_fall("en_cs");
    wait_rises(3, "en_bit3");
    enable = 1'b0;
    wait_valid("en_valid");
    chk("en_off_data", int'(adc_out), 8'h3C);
    step();
    n_cs = cs_falls;
    n_sclk = sclk_rises;
    n_valid = valid_cnt;
    steps(1000);
    chk("en_off_cs", cs_falls - n_cs, 0);
    chk("en_off_sclk", sclk_rises - n_sclk, 0);
    chk("en_off_valid", valid_cnt - n_valid, 0);
    chk("en_off_idle", int'(adc_cs_n), 1);
    chk("en_off_hold", int'(adc_out), 8'h3C);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_clear", int'(adc_out), 0);
    seq = {1'b0, 8'hA5};
    en_cyc = cyc;
    enable = 1'b1;
    wait_cs_fall("re_cs");
    chk("reenable_start", cs_cyc - en_cyc, 256);
    wait_rises(6, "rst_bit5");
    chk("rst_in_hi", int'(adc_sclk), 1);
    n_valid = valid_cnt;
    reset = 1'b1;
    enable = 1'b0;
    step();
    chk_idle("rst_mid");
    reset = 1'b0;
    steps(100);
    chk("rst_no_valid", valid_cnt - n_valid, 0);
    chk("rst_out_zero", int'(adc_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
Front end that produces the 8-bit temperature code consumed by the pipeline temperature controller's adc_out input. The block periodically reads a serial 8-bit ADC (ADC0831-style: chip-select, host-driven clock, MSB-first data, leading null bit). It presents each completed conversion as a held parallel word plus a one-cycle valid strobe. It sits between the ADC pins and the controller, in the same clk domain.

Parameters:
CLK_DIV, 4, clk cycles per adc_sclk half-period; must be >= 3 to cover sdo synchronizer latency.
SAMPLE_PERIOD, 256, clk cycles between conversion starts; must be >= conversion length (2*CLK_DIV*(LEAD_BITS+DATA_BITS) + 2*CLK_DIV).
DATA_BITS, 8, data bits per conversion; fixed to 8 for the controller interface.
LEAD_BITS, 1, leading null/start bits clocked out and discarded before data.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = run periodic conversions
adc_sdo  input  1  serial data from ADC, asynchronous to clk
adc_cs_n  output  1  ADC chip select, active low
adc_sclk  output  1  ADC serial clock
adc_out  output  8  last completed conversion, MSB = first data bit
adc_valid  output  1  one-cycle pulse when adc_out updates
busy  output  1  1 while a conversion is in progress (state != IDLE)

Behaviour:
- Reset (synchronous, active-high, overrides everything): state=IDLE, adc_cs_n=1, adc_sclk=0, adc_out=8'h00, adc_valid=0, busy=0, period counter=0, bit counter=0, shift register=0. Asserting reset mid-conversion aborts the conversion on that edge. No valid pulse is produced and adc_out stays 0.
- adc_sdo passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Period counter: counts 0..SAMPLE_PERIOD-1 while enable=1 and wraps. It is held at 0 while enable=0.
- A start tick occurs on the wrap edge (counter==SAMPLE_PERIOD-1, enable=1). If the state is IDLE, the FSM moves to CS_SETUP. If the state is not IDLE, the tick is dropped silently.
- FSM states: IDLE, CS_SETUP, SHIFT_LO, SHIFT_HI, CS_HOLD.
  - IDLE: cs_n=1, sclk=0.
  - CS_SETUP: cs_n=0, sclk=0 for CLK_DIV cycles, then SHIFT_LO.
  - SHIFT_LO: sclk=0 for CLK_DIV cycles, then SHIFT_HI.
  - SHIFT_HI: sclk=1 for CLK_DIV cycles.
    - On its last cycle, sample synced sdo. If the bit index >= LEAD_BITS, shift it in MSB-first. Then increment the bit index.
    - If the bit index was LEAD_BITS+DATA_BITS-1, go to CS_HOLD; otherwise go to SHIFT_LO.
  - CS_HOLD: cs_n=0, sclk=0 for CLK_DIV cycles. On the closing edge: cs_n->1, adc_out<=shift register, adc_valid<=1 for exactly one cycle, state->IDLE.
- adc_cs_n and adc_sclk are registered outputs with no combinational glitches.
- Latency: adc_valid rises 2*CLK_DIV*(LEAD_BITS+DATA_BITS)+2*CLK_DIV clk cycles after the edge where cs_n falls. This is 80 cycles with the defaults.
- adc_out holds its value between conversions and changes only on the valid edge.
- enable deasserted mid-conversion: the current conversion completes normally, including the valid pulse. No further starts occur.
- enable reasserted: the first start comes SAMPLE_PERIOD cycles after enable rises (counter restarts from 0).
- Lead bits are discarded regardless of value. Data bits are taken exactly as sampled, with no saturation or filtering. 8'hFF and 8'h00 pass through unchanged.

Decomposition:
- Shared package (adc_pkg): FSM state encoding (3-bit enum for the five states), ADC_DATA_W=8, and default timing constants (CLK_DIV, SAMPLE_PERIOD, LEAD_BITS).
- The controller's threshold constants (192, 255) also move into this package so producer and consumer share them.
- One sub-module: sync_2ff (generic 1-bit two-flop synchronizer, reset to 0) for adc_sdo.

Test Plan:
- Reset: hold reset 3 cycles with an arbitrary sdo pattern -> adc_cs_n=1, adc_sclk=0, adc_out=8'h00, adc_valid=0, busy=0 throughout and one cycle after release.
- Single conversion: enable=1, ADC model returns lead bit 0 then 8'hC0 -> cs_n falls at cycle 256, exactly 9 sclk rising edges, adc_valid single pulse 80 cycles later, adc_out=8'hC0 held until the next conversion.
- Boundary codes: consecutive conversions returning 8'hFF then 8'h00 -> adc_out=8'hFF then 8'h00, one valid pulse each, spaced 256 cycles apart.
- Lead bit discard: model drives lead bit 1 and data 8'h5A -> adc_out=8'h5A (not 8'hAD/8'hB4).
- Enable control: enable=0 for 1000 cycles -> no cs_n/sclk activity. Deassert enable during bit 3 -> conversion completes with valid, then no further cs_n falls.
- Reset mid-conversion: assert reset during SHIFT_HI of bit 5 -> next edge cs_n=1, sclk=0, busy=0, adc_out unchanged at 8'h00, no adc_valid.
